// File: rtl/regfile_dump.sv
// regfile_dump: 32x32 register file with two bypassed read ports and a handshaked register-dump stream
module regfile_dump #(
  parameter int REG_NUM   = 32,
  parameter int DUMP_LAST = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic        dump_start,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [4:0]  dump_addr,
  output logic [31:0] dump_data,
  output logic        dump_busy,
  output logic        dump_done
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [4:0] LAST = 5'(DUMP_LAST);
  logic [31:0] regs_q [REG_NUM];
  state_t      state_q;
  logic [4:0]  idx_q;
  logic [4:0]  idx_d;
  logic [31:0] beat_d;
  // Register array: cleared on reset, r0 is never written so it stays zero
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    else if (we && waddr != 5'd0) regs_q[waddr] <= wdata;
  end
  // Read ports: zero when masked, writeback data forwarded on an address match
  always_comb begin
    rdata1 = (rst || !re1 || raddr1 == 5'd0) ? 32'd0 : (we && waddr == raddr1) ? wdata : regs_q[raddr1];
    rdata2 = (rst || !re2 || raddr2 == 5'd0) ? 32'd0 : (we && waddr == raddr2) ? wdata : regs_q[raddr2];
  end
  // Next beat: a write landing on the same edge as the load is captured
  always_comb begin
    idx_d  = idx_q + 5'd1;
    beat_d = (we && waddr == idx_d) ? wdata : regs_q[idx_d];
  end
  // Dump FSM with registered stream outputs; start is only honoured in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      dump_valid <= 1'b0;
      dump_busy  <= 1'b0;
      dump_done  <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      dump_done <= 1'b0;
      if (state_q == IDLE) begin
        if (dump_start) begin
          state_q    <= RUN;
          idx_q      <= '0;
          dump_valid <= 1'b1;
          dump_busy  <= 1'b1;
          dump_addr  <= '0;
          dump_data  <= '0;
        end
      end else if (dump_ready) begin
        if (idx_q == LAST) begin
          state_q    <= IDLE;
          dump_valid <= 1'b0;
          dump_busy  <= 1'b0;
          dump_done  <= 1'b1;
        end else begin
          idx_q     <= idx_d;
          dump_addr <= idx_d;
          dump_data <= beat_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: randomized self-checking bench for regfile_dump against an array model
module tb_regfile_dump;
  logic        clk = 1'b0;
  logic        rst, we, re1, re2, dump_start, dump_ready;
  logic [4:0]  waddr, raddr1, raddr2, dump_addr;
  logic [31:0] wdata, rdata1, rdata2, dump_data;
  logic        dump_valid, dump_busy, dump_done;
  logic [31:0] model [32];
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  regfile_dump #(.REG_NUM(32), .DUMP_LAST(31)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_busy(dump_busy), .dump_done(dump_done)
  );

  function automatic logic [31:0] exp_read(logic en, logic [4:0] a);
    if (rst || !en || a == 5'd0) return 32'd0;
    if (we && waddr == a) return wdata;
    return model[a];
  endfunction

  task automatic step();
    if (rst) foreach (model[i]) model[i] = 32'd0;
    else if (we && waddr != 5'd0) model[waddr] = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; we = 0; waddr = 0; wdata = 0; re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
    dump_start = 0; dump_ready = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; we = 1; waddr = 5'd3; wdata = 32'hA5A5A5A5; re1 = 1; raddr1 = 5'd3;
    #1;
    vecs++; if (rdata1 !== 32'd0) begin errs++; $display("FAIL reset_comb_read got %h want 0", rdata1); end
    step();
    idle();
    #1;
    vecs++;
    if ({dump_valid, dump_busy, dump_done} !== 3'b000 || dump_addr !== 5'd0 || dump_data !== 32'd0) begin
      errs++; $display("FAIL reset_outputs got v%b b%b d%b a%0d d%h want all 0", dump_valid, dump_busy, dump_done, dump_addr, dump_data);
    end
    re1 = 1; raddr1 = 5'd3;
    #1;
    vecs++; if (rdata1 !== 32'd0) begin errs++; $display("FAIL reset_write_discard got %h want 0", rdata1); end
    idle();
  endtask

  task automatic test_write_read();
    we = 1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    step();
    idle(); re1 = 1; raddr1 = 5'd5;
    #1;
    vecs++; if (rdata1 !== 32'hDEADBEEF) begin errs++; $display("FAIL write_read got %h want deadbeef", rdata1); end
    re1 = 0;
    #1;
    vecs++; if (rdata1 !== 32'd0) begin errs++; $display("FAIL read_disabled got %h want 0", rdata1); end
  endtask

  task automatic test_bypass();
    we = 1; waddr = 5'd7; wdata = 32'h12345678; re2 = 1; raddr2 = 5'd7; re1 = 1; raddr1 = 5'd7;
    #1;
    vecs++; if (rdata2 !== 32'h12345678) begin errs++; $display("FAIL bypass got %h want 12345678", rdata2); end
    vecs++; if (rdata1 !== rdata2) begin errs++; $display("FAIL same_addr_ports got %h want %h", rdata1, rdata2); end
    step();
    idle();
  endtask

  task automatic test_zero_reg();
    we = 1; waddr = 5'd0; wdata = 32'hFFFFFFFF; re1 = 1; re2 = 1; raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    vecs++; if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin errs++; $display("FAIL zero_bypass got %h/%h want 0", rdata1, rdata2); end
    step();
    we = 0;
    #1;
    vecs++; if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin errs++; $display("FAIL zero_read got %h/%h want 0", rdata1, rdata2); end
    idle();
  endtask

  task automatic test_random_rw();
    logic [31:0] e1, e2;
    for (int k = 0; k < 200; k++) begin
      we = 1'($urandom_range(0, 1)); waddr = 5'($urandom); wdata = $urandom;
      re1 = ($urandom_range(0, 7) != 0); raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      re2 = ($urandom_range(0, 7) != 0); raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom);
      #1;
      e1 = exp_read(re1, raddr1); e2 = exp_read(re2, raddr2);
      vecs++; if (rdata1 !== e1) begin errs++; $display("FAIL rand_rd1 a%0d got %h want %h", raddr1, rdata1, e1); end
      vecs++; if (rdata2 !== e2) begin errs++; $display("FAIL rand_rd2 a%0d got %h want %h", raddr2, rdata2, e2); end
      step();
    end
    idle();
  endtask

  task automatic test_dump_backpressure();
    int n = 0;
    int cyc = 0;
    for (int r = 1; r < 32; r++) begin we = 1; waddr = 5'(r); wdata = r * 32'h11; step(); end
    idle();
    dump_start = 1;
    #1;
    vecs++; if (dump_valid !== 1'b0) begin errs++; $display("FAIL dump_idle_valid got %b want 0", dump_valid); end
    step();
    dump_start = 0;
    while (n < 32 && cyc < 200) begin
      dump_ready = cyc[0];
      #1;
      vecs++;
      if (dump_valid !== 1'b1 || dump_busy !== 1'b1 || dump_addr !== 5'(n) || dump_data !== n * 32'h11) begin
        errs++; $display("FAIL bp_beat n%0d got v%b a%0d d%h want v1 a%0d d%h", n, dump_valid, dump_addr, dump_data, n, n * 32'h11);
      end
      if (dump_ready) n++;
      step(); cyc++;
    end
    dump_ready = 0;
    vecs++; if (n != 32) begin errs++; $display("FAIL bp_timeout got %0d beats want 32", n); end
    vecs++; if ({dump_done, dump_valid, dump_busy} !== 3'b100) begin errs++; $display("FAIL bp_done got d%b v%b b%b want 100", dump_done, dump_valid, dump_busy); end
    step();
    vecs++; if (dump_done !== 1'b0) begin errs++; $display("FAIL bp_done_width got %b want 0", dump_done); end
  endtask

  task automatic test_dump_random();
    int n = 0;
    int cyc = 0;
    logic [31:0] exp_beat = 32'd0;
    logic [31:0] e1;
    idle(); dump_start = 1; step();
    while (n < 32 && cyc < 400) begin
      we = 1'($urandom_range(0, 1)); waddr = 5'($urandom); wdata = $urandom;
      re1 = 1; raddr1 = 5'($urandom);
      dump_ready = ($urandom_range(0, 3) != 0);
      dump_start = (n == 31 && dump_ready) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      e1 = exp_read(re1, raddr1);
      vecs++; if (rdata1 !== e1) begin errs++; $display("FAIL dump_rd a%0d got %h want %h", raddr1, rdata1, e1); end
      vecs++;
      if (dump_valid !== 1'b1 || dump_addr !== 5'(n) || dump_data !== exp_beat) begin
        errs++; $display("FAIL rand_beat n%0d got v%b a%0d d%h want a%0d d%h", n, dump_valid, dump_addr, dump_data, n, exp_beat);
      end
      if (dump_ready) begin
        step(); n++;
        if (n < 32) exp_beat = model[n];
      end else step();
      cyc++;
    end
    idle();
    vecs++; if (n != 32) begin errs++; $display("FAIL rand_timeout got %0d beats want 32", n); end
    vecs++; if ({dump_done, dump_valid, dump_busy} !== 3'b100) begin errs++; $display("FAIL start_in_final got d%b v%b b%b want 100", dump_done, dump_valid, dump_busy); end
    step();
  endtask

  task automatic test_back_to_back();
    int cnt = 0;
    idle(); dump_start = 1; step();
    dump_start = 0; dump_ready = 1;
    while (dump_valid && cnt < 40) begin cnt++; step(); end
    vecs++; if (cnt != 32) begin errs++; $display("FAIL full_speed_len got %0d want 32", cnt); end
    vecs++; if (dump_done !== 1'b1) begin errs++; $display("FAIL full_speed_done got %b want 1", dump_done); end
    dump_start = 1; step(); dump_start = 0; dump_ready = 0;
    vecs++;
    if ({dump_valid, dump_busy, dump_done} !== 3'b110 || dump_addr !== 5'd0 || dump_data !== 32'd0) begin
      errs++; $display("FAIL restart got v%b b%b d%b a%0d want 110 a0", dump_valid, dump_busy, dump_done, dump_addr);
    end
    dump_ready = 1; cnt = 0;
    while (dump_valid && cnt < 40) begin cnt++; step(); end
    idle(); step();
  endtask

  task automatic test_same_edge_capture();
    int cyc = 0;
    idle(); dump_start = 1; step();
    dump_start = 0; dump_ready = 1;
    step(); step(); step();
    vecs++; if (dump_addr !== 5'd3) begin errs++; $display("FAIL capture_idx got %0d want 3", dump_addr); end
    we = 1; waddr = 5'd4; wdata = 32'hCAFE0004;
    step();
    dump_ready = 0; wdata = 32'h0BADBAD0;
    #1;
    vecs++; if (dump_addr !== 5'd4 || dump_data !== 32'hCAFE0004) begin errs++; $display("FAIL capture got a%0d d%h want a4 cafe0004", dump_addr, dump_data); end
    step();
    we = 0;
    vecs++; if (dump_data !== 32'hCAFE0004) begin errs++; $display("FAIL held_after_write got %h want cafe0004", dump_data); end
    dump_ready = 1;
    while (dump_addr != 5'd10 && cyc < 20) begin step(); cyc++; end
    dump_ready = 0;
    vecs++; if (dump_addr !== 5'd10 || dump_valid !== 1'b1) begin errs++; $display("FAIL reach_idx10 got a%0d v%b want a10 v1", dump_addr, dump_valid); end
    rst = 1; we = 1; waddr = 5'd9; wdata = 32'h99999999;
    step();
    idle();
    vecs++; if ({dump_valid, dump_busy, dump_done} !== 3'b000) begin errs++; $display("FAIL abort got v%b b%b d%b want 000", dump_valid, dump_busy, dump_done); end
    step();
    vecs++; if (dump_done !== 1'b0) begin errs++; $display("FAIL abort_no_done got %b want 0", dump_done); end
    re1 = 1; re2 = 1;
    for (int r = 0; r < 32; r++) begin
      raddr1 = 5'(r); raddr2 = 5'(31 - r);
      #1;
      vecs++; if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin errs++; $display("FAIL cleared r%0d got %h/%h want 0", r, rdata1, rdata2); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_random_rw();
    test_dump_backpressure();
    test_dump_random();
    test_back_to_back();
    test_same_edge_capture();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 SHALL have parameter REG_NUM, default 32, meaning number of architectural registers; fixed at 32 for 5-bit addressing.
REQ-002 SHALL have parameter DUMP_LAST, default 31, meaning the highest register index streamed by the dump engine.
REQ-003 SHALL have the port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have the port rst  input  1  reset; synchronous, active-high (`RstEnable = 1'b1).
REQ-005 SHALL have the port we  input  1  write enable from the writeback stage.
REQ-006 SHALL have the port waddr  input  5  write register address.
REQ-007 SHALL have the port wdata  input  32  write data.
REQ-008 SHALL have the port re1  input  1  read-port-1 enable, driven by the decode stage's reg1 read request.
REQ-009 SHALL have the port raddr1  input  5  read-port-1 address.
REQ-010 SHALL have the port rdata1  output  32  read-port-1 data, combinational.
REQ-011 SHALL have the ports re2, raddr2 and rdata2, with the same widths, directions and meanings as port 1.
REQ-012 SHALL have the port dump_start  input  1  single-cycle request to stream all registers.
REQ-013 SHALL have the port dump_valid  output  1  dump beat valid.
REQ-014 SHALL have the port dump_ready  input  1  dump beat accepted by the consumer.
REQ-015 SHALL have the port dump_addr  output  5  index of the current beat.
REQ-016 SHALL have the port dump_data  output  32  contents of the current beat.
REQ-017 SHALL have the port dump_busy  output  1  high while the dump FSM is in state RUN.
REQ-018 SHALL have the port dump_done  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-019 SHALL hold 32 x 32-bit registers; register 0 SHALL read as 0 always, and writes to it SHALL be discarded.
REQ-020 SHALL write wdata to regs[waddr] at the rising edge when we=1, waddr!=0 and rst=0.
REQ-021 For each read port, rdata SHALL be 0 when rst=1, when re=0, or when raddr=0.
REQ-022 Otherwise, when we=1 and waddr==raddr, rdata SHALL return wdata in the same cycle (write-through bypass).
REQ-023 Otherwise, rdata SHALL return regs[raddr].
REQ-024 Both read ports SHALL be independent; the same address on both ports SHALL return identical data.
REQ-025 The dump FSM SHALL have the states IDLE and RUN.
REQ-026 IDLE with dump_start=1: the FSM SHALL go to RUN next cycle with idx=0; dump_valid=1, dump_addr=0, dump_data=0.
REQ-027 In RUN, dump_valid SHALL be 1, and dump_addr/dump_data SHALL stay stable while dump_ready=0.
REQ-028 In RUN with dump_ready=1 and idx<DUMP_LAST: idx SHALL increment, and the next beat SHALL be loaded at that edge.
REQ-029 The loaded dump_data SHALL be (we && waddr==idx+1) ? wdata : regs[idx+1], so a same-edge write is captured.
REQ-030 A write to an index already loaded or already sent SHALL NOT alter the beat being presented.
REQ-031 In RUN with dump_ready=1 and idx==DUMP_LAST: the FSM SHALL return to IDLE, dump_valid SHALL go 0, and dump_done SHALL be 1 for exactly the following cycle.
REQ-032 dump_start SHALL be ignored while in RUN, including in the final-accept cycle.
REQ-033 Dump latency SHALL be 1 cycle from start to first valid; with ready held high, a full dump SHALL take 32 valid cycles, and dump_done SHALL follow the last one.
REQ-034 Register reads and writes SHALL proceed unaffected during a dump.

Reset
REQ-035 On a rising edge with rst=1, all 32 registers SHALL clear to 0, the FSM SHALL enter IDLE, and idx SHALL be 0.
REQ-036 On that edge, dump_valid, dump_busy and dump_done SHALL go 0, and dump_addr and dump_data SHALL go 0.
REQ-037 Reset during RUN SHALL abort the dump with no dump_done pulse; a write presented in the reset cycle SHALL be discarded.
REQ-038 rdata1 and rdata2 SHALL be 0 combinationally while rst=1.

Verification
REQ-039 Write/read: write 0xDEADBEEF to r5, then re1=1 and raddr1=5 next cycle -> rdata1=0xDEADBEEF; re1=0 -> rdata1=0.
REQ-040 Bypass: we=1, waddr=7, wdata=0x12345678 with raddr2=7 and re2=1 in the same cycle -> rdata2=0x12345678 before the edge.
REQ-041 Zero register: write 0xFFFFFFFF to r0, then read r0 on both ports -> 0; bypass is suppressed for address 0.
REQ-042 Dump with backpressure: preload rN=N*0x11, start, ready toggling every cycle -> 32 beats with addr 0..31 and data N*0x11, each held stable while stalled, then one dump_done pulse.
REQ-043 Same-edge capture: during RUN at idx=3, accept the beat while writing r4=0xCAFE0004 -> the beat with dump_addr=4 carries 0xCAFE0004.
REQ-044 Reset mid-dump: assert rst at idx=10 -> next cycle dump_valid=0, dump_busy=0, no dump_done, and all registers read 0.
